// File: rtl/ex_unit.sv
// ex_unit: execute stage of the 5-stage LoongArch pipeline.
// Computes the ALU result, optionally runs a 32-step restoring divider,
// issues the data-SRAM request for ld.w/st.w and drives the EX->ME bus.
// Optional divider is compiled in with macro EX_DIV_EN.
// Ports:
//   clk, resetn                  clock, async active-low reset
//   ID_to_EX_Valid/_Bus          decoded instruction from ID (151 bits)
//   ME_Allow_in                  memory stage can accept
//   EX_Allow_in                  EX can accept a new instruction
//   EX_to_ME_Valid/_Bus          result handed to ME (71 bits)
//   data_sram_en/we/addr/wdata   data SRAM request
//   EX_dest, EX_Forward_Res      forwarding info for ID
//   EX_Load                      load in EX, for load-use stall in ID
module ex_unit (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ID_to_EX_Valid,
    input  logic         ME_Allow_in,
    output logic         EX_Allow_in,
    input  logic [150:0] ID_to_EX_Bus,
    output logic         EX_to_ME_Valid,
    output logic [70:0]  EX_to_ME_Bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [4:0]   EX_dest,
    output logic [31:0]  EX_Forward_Res,
    output logic         EX_Load
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 12;
    localparam int unsigned DEST_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [OP_W-1:0]   alu_op;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic              div_en;
        logic [1:0]        div_op;
        logic              mem_we;
        logic              res_from_mem;
        logic              gr_we;
        logic [DEST_W-1:0] dest;
        logic [XLEN-1:0]   rkd_value;
    } id_bus_t;

    id_bus_t         ex_q;
    logic            ex_valid;
    logic            ready_go;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] ex_result;

    // Pipeline valid bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid <= 1'b0;
        end else if (EX_Allow_in) begin
            ex_valid <= ID_to_EX_Valid;
        end
    end

    // Payload register, loads only when a new instruction is accepted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_q <= '0;
        end else if (ID_to_EX_Valid && EX_Allow_in) begin
            ex_q <= ID_to_EX_Bus;
        end
    end

    // One-hot ALU
    always_comb begin
        logic [4:0] sh;
        sh      = ex_q.src2[4:0];
        alu_res = '0;
        if (ex_q.alu_op[0])  alu_res = alu_res | (ex_q.src1 + ex_q.src2);
        if (ex_q.alu_op[1])  alu_res = alu_res | (ex_q.src1 - ex_q.src2);
        if (ex_q.alu_op[2])  alu_res = alu_res | {31'b0, $signed(ex_q.src1) < $signed(ex_q.src2)};
        if (ex_q.alu_op[3])  alu_res = alu_res | {31'b0, ex_q.src1 < ex_q.src2};
        if (ex_q.alu_op[4])  alu_res = alu_res | (ex_q.src1 & ex_q.src2);
        if (ex_q.alu_op[5])  alu_res = alu_res | ~(ex_q.src1 | ex_q.src2);
        if (ex_q.alu_op[6])  alu_res = alu_res | (ex_q.src1 | ex_q.src2);
        if (ex_q.alu_op[7])  alu_res = alu_res | (ex_q.src1 ^ ex_q.src2);
        if (ex_q.alu_op[8])  alu_res = alu_res | (ex_q.src1 << sh);
        if (ex_q.alu_op[9])  alu_res = alu_res | (ex_q.src1 >> sh);
        if (ex_q.alu_op[10]) alu_res = alu_res | XLEN'($signed(ex_q.src1) >>> sh);
        if (ex_q.alu_op[11]) alu_res = alu_res | ex_q.src2;
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    div_state_t      div_state;
    div_state_t      div_state_nxt;
    logic [4:0]      div_cnt;
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] div_r;
    logic [XLEN-1:0] div_d;
    logic            div_a_neg;
    logic            div_b_neg;
    logic            div_start_c;
    logic            op_signed_c;
    logic            src1_neg_c;
    logic            src2_neg_c;
    logic [XLEN:0]   step_tmp;
    logic            step_ge;
    logic [XLEN-1:0] step_r;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign div_start_c = ex_valid && ex_q.div_en;
    assign op_signed_c = !ex_q.div_op[1];
    assign src1_neg_c  = op_signed_c && ex_q.src1[XLEN-1];
    assign src2_neg_c  = op_signed_c && ex_q.src2[XLEN-1];

    // Restoring step: shift next dividend bit into the partial remainder.
    // A zero divisor always subtracts, giving q=all ones and r=dividend.
    assign step_tmp = {div_r, div_q[XLEN-1]};
    assign step_ge  = step_tmp >= {1'b0, div_d};
    assign step_r   = step_ge ? XLEN'(step_tmp - {1'b0, div_d}) : step_tmp[XLEN-1:0];

    // Sign fix-up; quotient of a divide by zero stays all ones
    assign q_fix = ((div_a_neg ^ div_b_neg) && (div_d != '0)) ? XLEN'(-div_q) : div_q;
    assign r_fix = div_a_neg ? XLEN'(-div_r) : div_r;

    // Divider state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_state <= DIV_IDLE;
        end else begin
            div_state <= div_state_nxt;
        end
    end

    // Divider next state
    always_comb begin
        div_state_nxt = div_state;
        case (div_state)
            DIV_IDLE: if (div_start_c)     div_state_nxt = DIV_BUSY;
            DIV_BUSY: if (div_cnt == 5'd31) div_state_nxt = DIV_DONE;
            DIV_DONE: if (ME_Allow_in)      div_state_nxt = DIV_IDLE;
            default:                        div_state_nxt = DIV_IDLE;
        endcase
    end

    // Divider datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt   <= '0;
            div_q     <= '0;
            div_r     <= '0;
            div_d     <= '0;
            div_a_neg <= 1'b0;
            div_b_neg <= 1'b0;
        end else if (div_state == DIV_IDLE && div_start_c) begin
            div_cnt   <= '0;
            div_r     <= '0;
            div_q     <= src1_neg_c ? XLEN'(-ex_q.src1) : ex_q.src1;
            div_d     <= src2_neg_c ? XLEN'(-ex_q.src2) : ex_q.src2;
            div_a_neg <= src1_neg_c;
            div_b_neg <= src2_neg_c;
        end else if (div_state == DIV_BUSY) begin
            div_cnt <= div_cnt + 5'd1;
            div_r   <= step_r;
            div_q   <= {div_q[XLEN-2:0], step_ge};
        end
    end

    assign ready_go  = !(ex_valid && ex_q.div_en) || (div_state == DIV_DONE);
    assign ex_result = ex_q.div_en ? (ex_q.div_op[0] ? r_fix : q_fix) : alu_res;
`else
    logic unused_div;

    assign unused_div = ^{ex_q.div_en, ex_q.div_op};
    assign ready_go   = 1'b1;
    assign ex_result  = alu_res;
`endif

    // Handshake and outgoing bus
    assign EX_Allow_in    = !ex_valid || (ready_go && ME_Allow_in);
    assign EX_to_ME_Valid = ex_valid && ready_go;
    assign EX_to_ME_Bus   = {ex_q.pc, ex_result, ex_q.res_from_mem, ex_q.gr_we, ex_q.dest};

    // Memory request only in the handoff cycle
    assign data_sram_en    = ex_valid && (ex_q.mem_we || ex_q.res_from_mem) && ME_Allow_in;
    assign data_sram_we    = {4{ex_valid && ex_q.mem_we && ME_Allow_in}};
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = ex_q.rkd_value;

    // Forwarding back to ID
    assign EX_dest        = ex_valid ? ex_q.dest : '0;
    assign EX_Forward_Res = ex_result;
    assign EX_Load        = ex_valid && ex_q.res_from_mem;

endmodule

// File: tb/tb_ex_unit.sv
module tb_ex_unit;

    logic         clk;
    logic         resetn;
    logic         ID_to_EX_Valid;
    logic         ME_Allow_in;
    logic         EX_Allow_in;
    logic [150:0] ID_to_EX_Bus;
    logic         EX_to_ME_Valid;
    logic [70:0]  EX_to_ME_Bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [4:0]   EX_dest;
    logic [31:0]  EX_Forward_Res;
    logic         EX_Load;

    int checks;
    int errors;

    ex_unit dut (
        .clk             (clk),
        .resetn          (resetn),
        .ID_to_EX_Valid  (ID_to_EX_Valid),
        .ME_Allow_in     (ME_Allow_in),
        .EX_Allow_in     (EX_Allow_in),
        .ID_to_EX_Bus    (ID_to_EX_Bus),
        .EX_to_ME_Valid  (EX_to_ME_Valid),
        .EX_to_ME_Bus    (EX_to_ME_Bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .EX_dest         (EX_dest),
        .EX_Forward_Res  (EX_Forward_Res),
        .EX_Load         (EX_Load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [150:0] mk(input logic [31:0] pc, input int op,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic de, input logic [1:0] dop,
                                        input logic mw, input logic rfm, input logic gw,
                                        input logic [4:0] dst, input logic [31:0] rkd);
        logic [11:0] oh;
        oh = 12'(1) << op;
        return {pc, oh, s1, s2, de, dop, mw, rfm, gw, dst, rkd};
    endfunction

    task automatic test_reset;
        #1;
        checks++; if (EX_to_ME_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", EX_to_ME_Valid); end
        checks++; if (EX_Allow_in !== 1'b1) begin errors++; $display("FAIL reset_allow got %b exp 1", EX_Allow_in); end
        checks++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'h0) begin errors++; $display("FAIL reset_sram got en=%b we=%h exp 0/0", data_sram_en, data_sram_we); end
        checks++; if (EX_dest !== 5'd0 || EX_Load !== 1'b0) begin errors++; $display("FAIL reset_fwd got dest=%0d load=%b exp 0/0", EX_dest, EX_Load); end
        checks++; if (EX_to_ME_Bus !== 71'd0) begin errors++; $display("FAIL reset_bus got %h exp 0", EX_to_ME_Bus); end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // All twelve ALU ops issued back to back; doubles as the throughput test
    task automatic test_alu_back_to_back;
        logic [31:0] s1  [12];
        logic [31:0] s2  [12];
        logic [31:0] exp [12];
        s1  = '{32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0,
                32'h12340000, 32'hFFFF0000, 32'd1, 32'h80000000, 32'h80000000, 32'd0};
        s2  = '{32'd7, 32'd7, 32'd1, 32'd1, 32'hFF00FF00, 32'h0F0F0000,
                32'h00005678, 32'h0F0F0F0F, 32'd35, 32'd4, 32'd4, 32'h12345000};
        exp = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hF000F000, 32'h00000F0F,
                32'h12345678, 32'hF0F00F0F, 32'd8, 32'h08000000, 32'hF8000000, 32'h12345000};
        ME_Allow_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ID_to_EX_Bus   = mk(32'h1000 + 32'(i * 4), i, s1[i], s2[i], 1'b0, 2'b00,
                                1'b0, 1'b0, 1'b1, 5'(i + 1), 32'd0);
            ID_to_EX_Valid = 1'b1;
            #1;
            checks++; if (EX_Allow_in !== 1'b1) begin errors++; $display("FAIL b2b_allow op%0d got %b exp 1", i, EX_Allow_in); end
            @(posedge clk); #1;
            checks++; if (EX_to_ME_Valid !== 1'b1 || EX_to_ME_Bus[38:7] !== exp[i])
                begin errors++; $display("FAIL alu_op%0d got v=%b res=%h exp v=1 res=%h", i, EX_to_ME_Valid, EX_to_ME_Bus[38:7], exp[i]); end
            checks++; if (EX_dest !== 5'(i + 1) || EX_Forward_Res !== exp[i])
                begin errors++; $display("FAIL fwd_op%0d got dest=%0d res=%h exp dest=%0d res=%h", i, EX_dest, EX_Forward_Res, i + 1, exp[i]); end
        end
        ID_to_EX_Valid = 1'b0;
    endtask

    task automatic test_store;
        ME_Allow_in    = 1'b1;
        ID_to_EX_Bus   = mk(32'h200, 0, 32'h0F00, 32'h0100, 1'b0, 2'b00,
                            1'b1, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF);
        ID_to_EX_Valid = 1'b1;
        @(posedge clk); #1;
        ID_to_EX_Valid = 1'b0;
        #1;
        checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'hF)
            begin errors++; $display("FAIL st_en got en=%b we=%h exp 1/f", data_sram_en, data_sram_we); end
        checks++; if (data_sram_addr !== 32'h1000 || data_sram_wdata !== 32'hDEADBEEF)
            begin errors++; $display("FAIL st_addr got addr=%h wdata=%h exp 00001000/deadbeef", data_sram_addr, data_sram_wdata); end
        @(posedge clk); #1;
        checks++; if (data_sram_en !== 1'b0 || EX_to_ME_Valid !== 1'b0)
            begin errors++; $display("FAIL st_after got en=%b v=%b exp 0/0", data_sram_en, EX_to_ME_Valid); end
    endtask

    task automatic test_load_stall;
        ME_Allow_in    = 1'b1;
        ID_to_EX_Bus   = mk(32'h40, 0, 32'h2000, 32'd4, 1'b0, 2'b00,
                            1'b0, 1'b1, 1'b1, 5'd4, 32'd0);
        ID_to_EX_Valid = 1'b1;
        @(posedge clk); #1;
        // ME stalls while a younger add waits in ID
        ME_Allow_in  = 1'b0;
        ID_to_EX_Bus = mk(32'h44, 0, 32'd1, 32'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd9, 32'd0);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (data_sram_en !== 1'b0 || EX_Allow_in !== 1'b0 || EX_Load !== 1'b1)
                begin errors++; $display("FAIL ld_stall%0d got en=%b allow=%b load=%b exp 0/0/1", k, data_sram_en, EX_Allow_in, EX_Load); end
            checks++; if (data_sram_addr !== 32'h2004 || EX_dest !== 5'd4)
                begin errors++; $display("FAIL ld_hold%0d got addr=%h dest=%0d exp 00002004/4", k, data_sram_addr, EX_dest); end
            @(posedge clk); #1;
        end
        ME_Allow_in = 1'b1;
        #1;
        checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'h0 || EX_Allow_in !== 1'b1)
            begin errors++; $display("FAIL ld_issue got en=%b we=%h allow=%b exp 1/0/1", data_sram_en, data_sram_we, EX_Allow_in); end
        checks++; if (data_sram_addr !== 32'h2004 || EX_to_ME_Bus[6] !== 1'b1)
            begin errors++; $display("FAIL ld_addr got addr=%h rfm=%b exp 00002004/1", data_sram_addr, EX_to_ME_Bus[6]); end
        @(posedge clk); #1;
        ID_to_EX_Valid = 1'b0;
        checks++; if (EX_to_ME_Bus[38:7] !== 32'd3 || EX_dest !== 5'd9 || EX_Load !== 1'b0)
            begin errors++; $display("FAIL ld_next got res=%h dest=%0d load=%b exp 3/9/0", EX_to_ME_Bus[38:7], EX_dest, EX_Load); end
        @(posedge clk); #1;
    endtask

`ifdef EX_DIV_EN
    task automatic run_div(input logic [1:0] dop, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int cyc);
        ME_Allow_in    = 1'b1;
        ID_to_EX_Bus   = mk(32'h300, 0, a, b, 1'b1, dop, 1'b0, 1'b0, 1'b1, 5'd7, 32'd0);
        ID_to_EX_Valid = 1'b1;
        @(posedge clk); #1;
        ID_to_EX_Valid = 1'b0;
        cyc = 1;
        while (!EX_to_ME_Valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        res = EX_to_ME_Bus[38:7];
    endtask

    task automatic test_div;
        logic [1:0]  dop [6];
        logic [31:0] a   [6];
        logic [31:0] b   [6];
        logic [31:0] exp [6];
        logic [31:0] res;
        int          cyc;
        dop = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        a   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000, 32'h80000000};
        b   = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        exp = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0};
        for (int i = 0; i < 6; i++) begin
            run_div(dop[i], a[i], b[i], res, cyc);
            checks++; if (cyc !== 34 || res !== exp[i])
                begin errors++; $display("FAIL div%0d got cyc=%0d res=%h exp cyc=34 res=%h", i, cyc, res, exp[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        ME_Allow_in    = 1'b1;
        ID_to_EX_Bus   = mk(32'h400, 0, 32'd100, 32'd7, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 5'd6, 32'd0);
        ID_to_EX_Valid = 1'b1;
        @(posedge clk); #1;
        ID_to_EX_Valid = 1'b0;
        checks++; if (EX_Allow_in !== 1'b0 || EX_to_ME_Valid !== 1'b0)
            begin errors++; $display("FAIL div_busy got allow=%b v=%b exp 0/0", EX_Allow_in, EX_to_ME_Valid); end
        repeat (11) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checks++; if (EX_to_ME_Valid !== 1'b0 || EX_Allow_in !== 1'b1 || EX_dest !== 5'd0)
            begin errors++; $display("FAIL abort got v=%b allow=%b dest=%0d exp 0/1/0", EX_to_ME_Valid, EX_Allow_in, EX_dest); end
        #1;
        resetn = 1'b1;
        ID_to_EX_Bus   = mk(32'h404, 0, 32'd20, 32'd22, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0);
        ID_to_EX_Valid = 1'b1;
        @(posedge clk); #1;
        ID_to_EX_Valid = 1'b0;
        checks++; if (EX_to_ME_Valid !== 1'b1 || EX_to_ME_Bus[38:7] !== 32'd42 || EX_dest !== 5'd5)
            begin errors++; $display("FAIL post_abort got v=%b res=%h dest=%0d exp 1/2a/5", EX_to_ME_Valid, EX_to_ME_Bus[38:7], EX_dest); end
        @(posedge clk); #1;
        checks++; if (EX_to_ME_Valid !== 1'b0)
            begin errors++; $display("FAIL post_abort_idle got v=%b exp 0", EX_to_ME_Valid); end
    endtask
`else
    task automatic test_div;
        ME_Allow_in    = 1'b1;
        ID_to_EX_Bus   = mk(32'h300, 1, 32'd10, 32'd3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 5'd7, 32'd0);
        ID_to_EX_Valid = 1'b1;
        @(posedge clk); #1;
        ID_to_EX_Valid = 1'b0;
        checks++; if (EX_to_ME_Valid !== 1'b1 || EX_to_ME_Bus[38:7] !== 32'd7)
            begin errors++; $display("FAIL div_ignored got v=%b res=%h exp 1/7", EX_to_ME_Valid, EX_to_ME_Bus[38:7]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        ME_Allow_in    = 1'b0;
        ID_to_EX_Bus   = mk(32'h400, 0, 32'h3000, 32'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 5'd6, 32'd0);
        ID_to_EX_Valid = 1'b1;
        @(posedge clk); #1;
        ID_to_EX_Valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checks++; if (EX_to_ME_Valid !== 1'b0 || EX_Load !== 1'b0 || EX_dest !== 5'd0)
            begin errors++; $display("FAIL abort got v=%b load=%b dest=%0d exp 0/0/0", EX_to_ME_Valid, EX_Load, EX_dest); end
        #1;
        resetn      = 1'b1;
        ME_Allow_in = 1'b1;
        ID_to_EX_Bus   = mk(32'h404, 0, 32'd20, 32'd22, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0);
        ID_to_EX_Valid = 1'b1;
        @(posedge clk); #1;
        ID_to_EX_Valid = 1'b0;
        checks++; if (EX_to_ME_Valid !== 1'b1 || EX_to_ME_Bus[38:7] !== 32'd42 || EX_dest !== 5'd5)
            begin errors++; $display("FAIL post_abort got v=%b res=%h dest=%0d exp 1/2a/5", EX_to_ME_Valid, EX_to_ME_Bus[38:7], EX_dest); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        checks         = 0;
        errors         = 0;
        resetn         = 1'b0;
        ID_to_EX_Valid = 1'b0;
        ME_Allow_in    = 1'b1;
        ID_to_EX_Bus   = '0;
        test_reset();
        test_alu_back_to_back();
        test_store();
        test_load_stall();
        test_div();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
